// File: rtl/fft_128_unload.sv
// Natural-order reorder buffer for the 128-point FFT result stream.
// Two ping-pong banks: one captures a bit-reversed frame while the other drains in bin order.
module fft_128_unload #(
   parameter int DW     = 32,
   parameter int N_LOG2 = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic [DW-1:0] din,
   input  logic          rd_en,
   output logic          oe,
   output logic [DW-1:0] dout,
   output logic          sof,
   output logic          full,
   output logic          ovf
);
   localparam int N = 1 << N_LOG2;
   localparam logic [N_LOG2-1:0] LAST = '1;

   logic [DW-1:0]     mem_q [0:2*N-1];
   logic [N_LOG2-1:0] wcnt_q, wcnt_d;
   logic [N_LOG2-1:0] rcnt_q, rcnt_d;
   logic              wsel_q, wsel_d;
   logic              rsel_q, rsel_d;
   logic              drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        bank_full_q, bank_full_d;
   logic              oe_q, sof_q;
   logic [DW-1:0]     dout_q;

   logic              frame_start;
   logic              dropping;
   logic              wr_en;
   logic              rd_issue;
   logic [N_LOG2-1:0] waddr;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) begin
         r[N_LOG2-1-i] = v[i];
      end
      return r;
   endfunction

   // The drop decision is taken on the first sample of a frame and held until its last.
   always_comb begin
      frame_start = ce && (wcnt_q == '0);
      dropping    = frame_start ? bank_full_q[wsel_q] : drop_q;
      wr_en       = ce && !dropping;
      waddr       = bitrev(wcnt_q);
      rd_issue    = rd_en && bank_full_q[rsel_q];

      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      wsel_d      = wsel_q;
      rsel_d      = rsel_q;
      drop_d      = drop_q;
      ovf_d       = ovf_q;
      bank_full_d = bank_full_q;

      if (rd_issue) begin
         rcnt_d = rcnt_q + N_LOG2'(1);
         if (rcnt_q == LAST) begin
            bank_full_d[rsel_q] = 1'b0;
            rsel_d              = ~rsel_q;
         end
      end

      if (ce) begin
         wcnt_d = wcnt_q + N_LOG2'(1);
         drop_d = dropping;
         if (frame_start && bank_full_q[wsel_q]) begin
            ovf_d = 1'b1;
         end
         if (wcnt_q == LAST) begin
            drop_d = 1'b0;
            if (!dropping) begin
               bank_full_d[wsel_q] = 1'b1;
               wsel_d              = ~wsel_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem_q[{wsel_q, waddr}] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         drop_q      <= 1'b0;
         ovf_q       <= 1'b0;
         bank_full_q <= '0;
         oe_q        <= 1'b0;
         sof_q       <= 1'b0;
         dout_q      <= '0;
      end else begin
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_d;
         bank_full_q <= bank_full_d;
         oe_q        <= rd_issue;
         sof_q       <= rd_issue && (rcnt_q == '0);
         if (rd_issue) begin
            dout_q <= mem_q[{rsel_q, rcnt_q}];
         end
      end
   end

   assign oe   = oe_q;
   assign sof  = sof_q;
   assign dout = dout_q;
   assign ovf  = ovf_q;
   assign full = bank_full_q[0] & bank_full_q[1];

endmodule

// File: tb/tb_fft_128_unload.sv
// Scoreboard bench for fft_128_unload: expected natural-order frames are queued as
// input frames are sent and popped by a negedge monitor whenever oe is high.
module tb_fft_128_unload;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic [31:0] din = '0;
   logic        rd_en = 1'b0;
   logic        oe;
   logic [31:0] dout;
   logic        sof;
   logic        full;
   logic        ovf;

   typedef struct packed {
      logic        sof;
      logic [31:0] data;
      logic [6:0]  bin;
   } exp_t;

   exp_t sb[$];
   exp_t monItem;
   int   testsRun = 0;
   int   testsFailed = 0;
   logic gapCheck = 1'b0;
   logic midFrame = 1'b0;
   logic fullSeen = 1'b0;

   fft_128_unload #(.DW(32), .N_LOG2(7)) dut (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .din   (din),
      .rd_en (rd_en),
      .oe    (oe),
      .dout  (dout),
      .sof   (sof),
      .full  (full),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] bitrev7(input logic [6:0] v);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) begin
         r[6-i] = v[i];
      end
      return r;
   endfunction

   // Output monitor: every oe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (full === 1'b1) fullSeen = 1'b1;
      if (gapCheck && midFrame) begin
         testsRun++;
         if (oe !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL oe_gap: oe=%b inside a frame, required 1", oe);
         end
      end
      if (oe === 1'b1) begin
         testsRun++;
         if (sb.size() == 0) begin
            testsFailed++;
            midFrame = 1'b0;
            $display("[TB] FAIL unexpected_oe: dout=%h sof=%b, required no output", dout, sof);
         end else begin
            monItem  = sb.pop_front();
            midFrame = (monItem.bin != 7'd127);
            if (dout !== monItem.data || sof !== monItem.sof) begin
               testsFailed++;
               $display("[TB] FAIL sample_bin%0d: dout=%h sof=%b, required dout=%h sof=%b",
                        monItem.bin, dout, sof, monItem.data, monItem.sof);
            end
         end
      end
   end

   task automatic sendFrame(input logic [15:0] tag, input int count, input bit expectKept);
      exp_t item;
      if (expectKept) begin
         for (int k = 0; k < 128; k++) begin
            item.sof  = (k == 0);
            item.data = {tag, 9'b0, 7'(k)};
            item.bin  = 7'(k);
            sb.push_back(item);
         end
      end
      for (int n = 0; n < count; n++) begin
         ce  = 1'b1;
         din = {tag, 9'b0, bitrev7(7'(n))};
         @(negedge clk);
      end
      ce  = 1'b0;
      din = $urandom;
   endtask

   task automatic waitDrain(input int maxCycles);
      int c = 0;
      while (sb.size() != 0 && c < maxCycles) begin
         @(negedge clk);
         c++;
      end
      testsRun++;
      if (sb.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain_timeout: %0d samples outstanding, required 0", sb.size());
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic oeSeen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rst   = 1'b0;
         ce    = 1'($urandom);
         din   = $urandom;
         rd_en = 1'($urandom);
         @(negedge clk);
      end
      testsRun += 5;
      if (oe !== 1'b0)    begin testsFailed++; $display("[TB] FAIL reset_oe: %b, required 0", oe); end
      if (sof !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_sof: %b, required 0", sof); end
      if (dout !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_dout: %h, required 0", dout); end
      if (full !== 1'b0)  begin testsFailed++; $display("[TB] FAIL reset_full: %b, required 0", full); end
      if (ovf !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_ovf: %b, required 0", ovf); end
      rst   = 1'b1;
      ce    = 1'b0;
      rd_en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (oe !== 1'b0) oeSeen = 1'b1;
      end
      testsRun++;
      if (oeSeen) begin
         testsFailed++;
         $display("[TB] FAIL idle_oe: oe seen=1 with no frame, required 0");
      end
   endtask

   task automatic test_single_frame();
      rd_en = 1'b1;
      sendFrame(16'h0000, 128, 1'b1);
      testsRun++;
      if (oe !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL latency_t1: oe=%b one cycle after last ce, required 0", oe);
      end
      @(negedge clk);
      testsRun++;
      if (oe !== 1'b1 || sof !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL latency_t2: oe=%b sof=%b two cycles after last ce, required 1 1", oe, sof);
      end
      waitDrain(200);
      testsRun++;
      if (ovf !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_ovf: %b, required 0", ovf);
      end
   endtask

   task automatic test_back_to_back();
      fullSeen = 1'b0;
      gapCheck = 1'b1;
      rd_en    = 1'b1;
      for (int f = 0; f < 4; f++) begin
         sendFrame(16'(f), 128, 1'b1);
      end
      waitDrain(400);
      gapCheck = 1'b0;
      testsRun += 2;
      if (fullSeen !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL stream_full: full seen=%b, required 0", fullSeen);
      end
      if (ovf !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL stream_ovf: %b, required 0", ovf);
      end
   endtask

   task automatic test_stalled_drain();
      int   remaining = 128;
      logic pend;
      rd_en = 1'b0;
      sendFrame(16'h0005, 128, 1'b1);
      for (int c = 0; c < 262; c++) begin
         rd_en = 1'(c % 2);
         pend  = rd_en && (remaining > 0);
         if (pend) remaining--;
         @(negedge clk);
         testsRun++;
         if (oe !== pend) begin
            testsFailed++;
            $display("[TB] FAIL stall_oe_cycle%0d: oe=%b, required %b", c, oe, pend);
         end
      end
      rd_en = 1'b0;
      waitDrain(10);
   endtask

   task automatic test_backpressure_drop();
      rd_en = 1'b0;
      sendFrame(16'h0001, 128, 1'b1);
      sendFrame(16'h0002, 128, 1'b1);
      testsRun += 2;
      if (full !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL drop_full: %b after two frames, required 1", full);
      end
      if (ovf !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL drop_ovf_early: %b, required 0", ovf);
      end
      sendFrame(16'h0003, 128, 1'b0);
      testsRun++;
      if (ovf !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL drop_ovf: %b after third frame, required 1", ovf);
      end
      rd_en = 1'b1;
      waitDrain(400);
      repeat (140) @(negedge clk);
      testsRun += 2;
      if (ovf !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL drop_ovf_sticky: %b after drain, required 1", ovf);
      end
      if (full !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL drop_full_after: %b after drain, required 0", full);
      end
   endtask

   task automatic test_mid_frame_reset();
      rd_en = 1'b1;
      sendFrame(16'h0006, 60, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sendFrame(16'h0007, 128, 1'b1);
      waitDrain(300);
      repeat (140) @(negedge clk);
      testsRun++;
      if (ovf !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_ovf: %b, required 0", ovf);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stalled_drain();
      test_backpressure_drop();
      test_mid_frame_reset();
      testsRun++;
      if (sb.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_end: %0d left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
